// File: rtl/bgpu_dispatch_pkg.sv
// Shared types and constants for the warp/block dispatcher.
package bgpu_dispatch_pkg;

    localparam int unsigned DefPcWidth      = 32;
    localparam int unsigned DefNumWarps     = 8;
    localparam int unsigned DefWarpWidth    = 32;
    localparam int unsigned DefBlockIdWidth = 8;
    localparam int unsigned DefWidWidth     = $clog2(DefNumWarps);
    localparam int unsigned DefNwWidth      = $clog2(DefNumWarps + 1);

    typedef logic [DefPcWidth-1:0]      pc_t;
    typedef logic [DefWidWidth-1:0]     wid_t;
    typedef logic [DefNwWidth-1:0]      nw_t;
    typedef logic [DefWarpWidth-1:0]    mask_t;
    typedef logic [DefBlockIdWidth-1:0] block_id_t;

    localparam mask_t AllOnesMask = {DefWarpWidth{1'b1}};

    typedef struct packed {
        logic      valid;
        block_id_t block_id;
        nw_t       remaining;
    } slot_t;

    typedef enum logic [0:0] {StIdle, StAlloc} state_e;

endpackage

// File: rtl/lzc_onehot_picker.sv
// Lowest-set-bit finder: index of the lowest asserted request and a valid flag.
module lzc_onehot_picker #(
    parameter int unsigned Width    = 8,
    parameter int unsigned IdxWidth = (Width > 1) ? $clog2(Width) : 1
) (
    input  logic [Width-1:0]    req_i,
    output logic [IdxWidth-1:0] idx_o,
    output logic                valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = Width - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = IdxWidth'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/warp_block_dispatcher.sv
// Accepts thread-block launches, initializes one warp per cycle and reports block
// completion once every warp of the block has stopped.
module warp_block_dispatcher
    import bgpu_dispatch_pkg::*;
#(
    parameter int unsigned PcWidth      = DefPcWidth,
    parameter int unsigned NumWarps     = DefNumWarps,
    parameter int unsigned WarpWidth    = DefWarpWidth,
    parameter int unsigned BlockIdWidth = DefBlockIdWidth,
    parameter int unsigned WidWidth     = $clog2(NumWarps),
    parameter int unsigned NwWidth      = $clog2(NumWarps + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    launch_valid_i,
    output logic                    launch_ready_o,
    input  logic [PcWidth-1:0]      launch_pc_i,
    input  logic [NwWidth-1:0]      launch_num_warps_i,
    input  logic [WarpWidth-1:0]    launch_last_mask_i,
    input  logic [BlockIdWidth-1:0] launch_block_id_i,
    output logic                    launch_err_o,
    output logic                    init_valid_o,
    output logic [WidWidth-1:0]     init_warp_id_o,
    output logic [PcWidth-1:0]      init_pc_o,
    output logic [WarpWidth-1:0]    init_act_mask_o,
    input  logic [NumWarps-1:0]     warp_stopped_i,
    output logic                    done_valid_o,
    input  logic                    done_ready_i,
    output logic [BlockIdWidth-1:0] done_block_id_o,
    output logic                    busy_o
);

    state_e                           state_q, state_d;
    logic [NumWarps-1:0]              busy_q, busy_d, armed_q, armed_d;
    logic [NumWarps-1:0][WidWidth-1:0] slot_of_q, slot_of_d;
    slot_t [NumWarps-1:0]             slots_q, slots_d;
    pc_t                              pc_q, pc_d;
    mask_t                            last_mask_q, last_mask_d;
    nw_t                              pending_q, pending_d;
    wid_t                             cur_slot_q, cur_slot_d;
    logic                             err_q, err_d;
    logic                             done_valid_q, done_valid_d;
    block_id_t                        done_id_q, done_id_d;

    logic [WidWidth-1:0] free_idx, ret_idx, free_slot, ret_slot;
    logic                free_valid, ret_valid, stall, legal;
    logic [NwWidth-1:0]  free_cnt;

    lzc_onehot_picker #(.Width(NumWarps), .IdxWidth(WidWidth)) u_free_pick (
        .req_i   (~busy_q),
        .idx_o   (free_idx),
        .valid_o (free_valid)
    );

    lzc_onehot_picker #(.Width(NumWarps), .IdxWidth(WidWidth)) u_ret_pick (
        .req_i   (busy_q & armed_q & warp_stopped_i),
        .idx_o   (ret_idx),
        .valid_o (ret_valid)
    );

    always_comb begin
        free_cnt  = '0;
        free_slot = '0;
        for (int i = NumWarps - 1; i >= 0; i--) begin
            free_cnt = free_cnt + NwWidth'(!busy_q[i]);
            if (!slots_q[i].valid) free_slot = WidWidth'(i);
        end
    end

    assign legal    = (launch_num_warps_i != '0) && (launch_num_warps_i <= NwWidth'(NumWarps));
    assign stall    = done_valid_q && !done_ready_i;
    assign ret_slot = slot_of_q[ret_idx];

    always_comb begin
        state_d         = state_q;
        busy_d          = busy_q;
        // A warp is armed one cycle after its init, masking the stale stopped level.
        armed_d         = busy_q;
        slot_of_d       = slot_of_q;
        slots_d         = slots_q;
        pc_d            = pc_q;
        last_mask_d     = last_mask_q;
        pending_d       = pending_q;
        cur_slot_d      = cur_slot_q;
        err_d           = 1'b0;
        done_valid_d    = done_valid_q && !done_ready_i;
        done_id_d       = done_id_q;
        launch_ready_o  = 1'b0;
        init_valid_o    = 1'b0;
        init_warp_id_o  = '0;
        init_pc_o       = '0;
        init_act_mask_o = '0;

        if (ret_valid && !stall) begin
            busy_d[ret_idx]            = 1'b0;
            armed_d[ret_idx]           = 1'b0;
            slots_d[ret_slot].remaining = slots_q[ret_slot].remaining - nw_t'(1);
            if (slots_q[ret_slot].remaining == nw_t'(1)) begin
                slots_d[ret_slot].valid = 1'b0;
                done_valid_d            = 1'b1;
                done_id_d               = slots_q[ret_slot].block_id;
            end
        end

        unique case (state_q)
            StIdle: begin
                launch_ready_o = !legal || (free_cnt >= launch_num_warps_i);
                if (launch_valid_i && launch_ready_o) begin
                    if (!legal) begin
                        err_d = 1'b1;
                    end else begin
                        pc_d        = launch_pc_i;
                        last_mask_d = launch_last_mask_i;
                        pending_d   = launch_num_warps_i;
                        cur_slot_d  = free_slot;
                        slots_d[free_slot].valid     = 1'b1;
                        slots_d[free_slot].block_id  = launch_block_id_i;
                        slots_d[free_slot].remaining = launch_num_warps_i;
                        state_d     = StAlloc;
                    end
                end
            end
            StAlloc: begin
                if (free_valid) begin
                    init_valid_o       = 1'b1;
                    init_warp_id_o     = free_idx;
                    init_pc_o          = pc_q;
                    init_act_mask_o    = (pending_q == nw_t'(1)) ? last_mask_q : AllOnesMask;
                    busy_d[free_idx]   = 1'b1;
                    armed_d[free_idx]  = 1'b0;
                    slot_of_d[free_idx] = cur_slot_q;
                    pending_d          = pending_q - nw_t'(1);
                    if (pending_q == nw_t'(1)) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            busy_q       <= '0;
            armed_q      <= '0;
            slot_of_q    <= '0;
            slots_q      <= '0;
            pc_q         <= '0;
            last_mask_q  <= '0;
            pending_q    <= '0;
            cur_slot_q   <= '0;
            err_q        <= 1'b0;
            done_valid_q <= 1'b0;
            done_id_q    <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            armed_q      <= armed_d;
            slot_of_q    <= slot_of_d;
            slots_q      <= slots_d;
            pc_q         <= pc_d;
            last_mask_q  <= last_mask_d;
            pending_q    <= pending_d;
            cur_slot_q   <= cur_slot_d;
            err_q        <= err_d;
            done_valid_q <= done_valid_d;
            done_id_q    <= done_id_d;
        end
    end

    assign launch_err_o    = err_q;
    assign done_valid_o    = done_valid_q;
    assign done_block_id_o = done_id_q;
    assign busy_o          = (|busy_q) || (state_q != StIdle);

endmodule

// File: tb/tb_warp_block_dispatcher.sv
// Directed bench for warp_block_dispatcher with hand-computed expectations.
module tb_warp_block_dispatcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        launch_valid;
    logic        launch_ready;
    logic [31:0] launch_pc;
    logic [3:0]  launch_num_warps;
    logic [31:0] launch_last_mask;
    logic [7:0]  launch_block_id;
    logic        launch_err;
    logic        init_valid;
    logic [2:0]  init_warp_id;
    logic [31:0] init_pc;
    logic [31:0] init_act_mask;
    logic [7:0]  warp_stopped;
    logic        done_valid;
    logic        done_ready;
    logic [7:0]  done_block_id;
    logic        busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    warp_block_dispatcher dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .launch_valid_i     (launch_valid),
        .launch_ready_o     (launch_ready),
        .launch_pc_i        (launch_pc),
        .launch_num_warps_i (launch_num_warps),
        .launch_last_mask_i (launch_last_mask),
        .launch_block_id_i  (launch_block_id),
        .launch_err_o       (launch_err),
        .init_valid_o       (init_valid),
        .init_warp_id_o     (init_warp_id),
        .init_pc_o          (init_pc),
        .init_act_mask_o    (init_act_mask),
        .warp_stopped_i     (warp_stopped),
        .done_valid_o       (done_valid),
        .done_ready_i       (done_ready),
        .done_block_id_o    (done_block_id),
        .busy_o             (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_init(input string tag, input logic [2:0] wid, input logic [31:0] pc,
                              input logic [31:0] mask);
        check({tag, "_valid"}, 64'(init_valid), 64'd1);
        check({tag, "_wid"}, 64'(init_warp_id), 64'(wid));
        check({tag, "_pc"}, 64'(init_pc), 64'(pc));
        check({tag, "_mask"}, 64'(init_act_mask), 64'(mask));
    endtask

    initial begin
        rst = 1'b1;
        launch_valid = 1'b0;
        launch_pc = '0;
        launch_num_warps = '0;
        launch_last_mask = '0;
        launch_block_id = '0;
        warp_stopped = '0;
        done_ready = 1'b0;
        tick();
        tick();

        // Reset state (num_warps 0 is illegal, so ready reads 1)
        check("rst_ready", 64'(launch_ready), 64'd1);
        check("rst_init", 64'(init_valid), 64'd0);
        check("rst_done", 64'(done_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(launch_err), 64'd0);
        rst = 1'b0;

        // Single 3-warp launch
        launch_valid = 1'b1; launch_num_warps = 4'd3; launch_pc = 32'h100;
        launch_last_mask = 32'h0000_00FF; launch_block_id = 8'hA1;
        check("s1_ready", 64'(launch_ready), 64'd1);
        tick();
        launch_valid = 1'b0; launch_num_warps = 4'd0;
        check_init("s1_w0", 3'd0, 32'h100, 32'hFFFF_FFFF);
        check("s1_ready_alloc", 64'(launch_ready), 64'd0);
        tick();
        check_init("s1_w1", 3'd1, 32'h100, 32'hFFFF_FFFF);
        tick();
        check_init("s1_w2", 3'd2, 32'h100, 32'h0000_00FF);
        tick();
        check("s1_idle_init", 64'(init_valid), 64'd0);
        check("s1_busy", 64'(busy), 64'd1);
        warp_stopped = 8'h07;
        tick();
        check("s1_done_r1", 64'(done_valid), 64'd0);
        tick();
        check("s1_done_r2", 64'(done_valid), 64'd0);
        tick();
        check("s1_done_r3", 64'(done_valid), 64'd1);
        check("s1_done_id", 64'(done_block_id), 64'hA1);
        tick();
        check("s1_done_hold", 64'(done_valid), 64'd1);
        check("s1_done_hold_id", 64'(done_block_id), 64'hA1);
        done_ready = 1'b1;
        tick();
        check("s1_done_pop", 64'(done_valid), 64'd0);
        tick();
        check("s1_done_once", 64'(done_valid), 64'd0);
        check("s1_busy_end", 64'(busy), 64'd0);

        // Over-subscription: 6 warps then 4 warps
        warp_stopped = 8'h00;
        launch_valid = 1'b1; launch_num_warps = 4'd6; launch_pc = 32'h200;
        launch_last_mask = 32'h3; launch_block_id = 8'hB1;
        tick();
        launch_num_warps = 4'd4; launch_pc = 32'h300;
        launch_last_mask = 32'h0F0F; launch_block_id = 8'hB2;
        check_init("s2_w0", 3'd0, 32'h200, 32'hFFFF_FFFF);
        for (int i = 1; i < 6; i++) begin
            tick();
            check_init("s2_wn", 3'(i), 32'h200, (i == 5) ? 32'h3 : 32'hFFFF_FFFF);
        end
        tick();
        check("s2_idle_init", 64'(init_valid), 64'd0);
        check("s2_held", 64'(launch_ready), 64'd0);
        warp_stopped = 8'h03;
        tick();
        check("s2_held_r1", 64'(launch_ready), 64'd0);
        tick();
        check("s2_ready_r2", 64'(launch_ready), 64'd1);
        warp_stopped = 8'h00;
        tick();
        launch_valid = 1'b0; launch_num_warps = 4'd0;
        check_init("s2b_w0", 3'd0, 32'h300, 32'hFFFF_FFFF);
        tick();
        check_init("s2b_w1", 3'd1, 32'h300, 32'hFFFF_FFFF);
        tick();
        check_init("s2b_w6", 3'd6, 32'h300, 32'hFFFF_FFFF);
        tick();
        check_init("s2b_w7", 3'd7, 32'h300, 32'h0F0F);
        tick();

        // All warps stop at once; completion back-pressure
        done_ready = 1'b0;
        launch_num_warps = 4'd7;
        warp_stopped = 8'hFF;
        for (int i = 0; i < 5; i++) tick();
        check("s3_no_done_yet", 64'(done_valid), 64'd0);
        tick();
        check("s3_done_b1", 64'(done_valid), 64'd1);
        check("s3_done_b1_id", 64'(done_block_id), 64'hB1);
        check("s3_free6", 64'(launch_ready), 64'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("s3_stall_valid", 64'(done_valid), 64'd1);
            check("s3_stall_id", 64'(done_block_id), 64'hB1);
            check("s3_stall_noretire", 64'(launch_ready), 64'd0);
        end
        done_ready = 1'b1;
        tick();
        check("s3_pop_b1", 64'(done_valid), 64'd0);
        check("s3_free7", 64'(launch_ready), 64'd1);
        tick();
        check("s3_done_b2", 64'(done_valid), 64'd1);
        check("s3_done_b2_id", 64'(done_block_id), 64'hB2);
        tick();
        check("s3_pop_b2", 64'(done_valid), 64'd0);
        check("s3_busy_end", 64'(busy), 64'd0);

        // Illegal launches
        warp_stopped = 8'h00;
        launch_valid = 1'b1; launch_num_warps = 4'd0;
        check("s4_ready0", 64'(launch_ready), 64'd1);
        tick();
        launch_valid = 1'b0;
        check("s4_err0", 64'(launch_err), 64'd1);
        check("s4_noinit0", 64'(init_valid), 64'd0);
        tick();
        check("s4_err0_clr", 64'(launch_err), 64'd0);
        check("s4_busy0", 64'(busy), 64'd0);
        launch_valid = 1'b1; launch_num_warps = 4'd9;
        check("s4_ready9", 64'(launch_ready), 64'd1);
        tick();
        launch_valid = 1'b0;
        check("s4_err9", 64'(launch_err), 64'd1);
        check("s4_noinit9", 64'(init_valid), 64'd0);
        tick();
        check("s4_err9_clr", 64'(launch_err), 64'd0);
        check("s4_busy9", 64'(busy), 64'd0);

        // Reset in the middle of allocation
        launch_valid = 1'b1; launch_num_warps = 4'd5; launch_pc = 32'h400;
        launch_last_mask = 32'h1F; launch_block_id = 8'hC1;
        tick();
        launch_valid = 1'b0;
        check_init("s5_w0", 3'd0, 32'h400, 32'hFFFF_FFFF);
        tick();
        check_init("s5_w1", 3'd1, 32'h400, 32'hFFFF_FFFF);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("s5_init", 64'(init_valid), 64'd0);
        check("s5_wid", 64'(init_warp_id), 64'd0);
        check("s5_pc", 64'(init_pc), 64'd0);
        check("s5_mask", 64'(init_act_mask), 64'd0);
        check("s5_busy", 64'(busy), 64'd0);
        check("s5_done", 64'(done_valid), 64'd0);
        check("s5_err", 64'(launch_err), 64'd0);
        launch_valid = 1'b1; launch_num_warps = 4'd8; launch_pc = 32'h500;
        launch_last_mask = 32'hAAAA; launch_block_id = 8'hD1;
        check("s5_ready8", 64'(launch_ready), 64'd1);
        tick();
        launch_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_init("s5b_wn", 3'(i), 32'h500, (i == 7) ? 32'hAAAA : 32'hFFFF_FFFF);
            tick();
        end
        check("s5b_idle", 64'(init_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
